// File: rtl/tinyriscv_pkg.sv
// Shared pipeline-control types: hold flag encodings, bus widths and the pipe_ctrl state enum.
package tinyriscv_pkg;
  localparam int InstAddrW = 32;
  localparam int RegAddrW  = 5;
  localparam int HoldW     = 2;

  typedef logic [InstAddrW-1:0] inst_addr_t;
  typedef logic [RegAddrW-1:0]  reg_addr_t;
  typedef logic [HoldW-1:0]     hold_flag_t;   // Hold_Flag_Bus

  localparam hold_flag_t Pipe_Flow  = 2'd0;
  localparam hold_flag_t Pipe_Hold  = 2'd1;
  localparam hold_flag_t Pipe_Clear = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    MDU_WAIT = 2'd2
  } pipe_state_e;
endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus; perf counter signals exist only with PIPE_CTRL_PERF_EN.
interface pipe_ctrl_if;
  import tinyriscv_pkg::*;
  logic       jump_req_i;
  inst_addr_t jump_addr_i;
  logic       int_req_i;
  inst_addr_t int_addr_i;
  logic       ex_load_i;
  reg_addr_t  ex_rd_i;
  logic       id_rs1_re_i;
  reg_addr_t  id_rs1_i;
  logic       id_rs2_re_i;
  reg_addr_t  id_rs2_i;
  logic       mdu_start_i;
  logic       mdu_done_i;
  hold_flag_t hold_pc_o;
  hold_flag_t hold_if_o;
  hold_flag_t hold_id_o;
  logic       jump_flag_o;
  inst_addr_t jump_addr_o;
  logic       int_ack_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  modport slave (
    input  jump_req_i, jump_addr_i, int_req_i, int_addr_i, ex_load_i, ex_rd_i,
           id_rs1_re_i, id_rs1_i, id_rs2_re_i, id_rs2_i, mdu_start_i, mdu_done_i,
    output hold_pc_o, hold_if_o, hold_id_o, jump_flag_o, jump_addr_o, int_ack_o
`ifdef PIPE_CTRL_PERF_EN
    , output stall_cnt_o, flush_cnt_o
`endif
  );

  modport master (
    output jump_req_i, jump_addr_i, int_req_i, int_addr_i, ex_load_i, ex_rd_i,
           id_rs1_re_i, id_rs1_i, id_rs2_re_i, id_rs2_i, mdu_start_i, mdu_done_i,
    input  hold_pc_o, hold_if_o, hold_id_o, jump_flag_o, jump_addr_o, int_ack_o
`ifdef PIPE_CTRL_PERF_EN
    , input stall_cnt_o, flush_cnt_o
`endif
  );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers read in ID.
module hazard_detect
  import tinyriscv_pkg::*;
(
  input  logic      ex_load_i,
  input  reg_addr_t ex_rd_i,
  input  logic      id_rs1_re_i,
  input  reg_addr_t id_rs1_i,
  input  logic      id_rs2_re_i,
  input  reg_addr_t id_rs2_i,
  output logic      load_use_o
);
  // x0 never carries a dependency
  assign load_use_o = ex_load_i && (ex_rd_i != '0) &&
                      ((id_rs1_re_i && (id_rs1_i == ex_rd_i)) ||
                       (id_rs2_re_i && (id_rs2_i == ex_rd_i)));
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush/redirect controller. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import tinyriscv_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  pipe_ctrl_if.slave  bus
);
  pipe_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        load_use;
  hold_flag_t  hold_pc, hold_if, hold_id;
  logic        jflag, ack;
  inst_addr_t  jaddr;

  hazard_detect u_hazard (
    .ex_load_i   (bus.ex_load_i),
    .ex_rd_i     (bus.ex_rd_i),
    .id_rs1_re_i (bus.id_rs1_re_i),
    .id_rs1_i    (bus.id_rs1_i),
    .id_rs2_re_i (bus.id_rs2_re_i),
    .id_rs2_i    (bus.id_rs2_i),
    .load_use_o  (load_use)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_pc = Pipe_Flow;
    hold_if = Pipe_Flow;
    hold_id = Pipe_Flow;
    jflag   = 1'b0;
    jaddr   = '0;
    ack     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.jump_req_i || bus.int_req_i) begin
          jflag   = 1'b1;
          jaddr   = bus.jump_req_i ? bus.jump_addr_i : bus.int_addr_i;
          ack     = !bus.jump_req_i;
          hold_if = Pipe_Clear;
          hold_id = Pipe_Clear;
          if (FLUSH_CYCLES != 0) begin
            state_d = FLUSH;
            cnt_d   = 3'(FLUSH_CYCLES);
          end
        end else if (bus.mdu_start_i) begin
          hold_pc = Pipe_Hold;
          hold_if = Pipe_Hold;
          hold_id = Pipe_Hold;
          if (!bus.mdu_done_i) state_d = MDU_WAIT;
        end else if (load_use) begin
          hold_pc = Pipe_Hold;
          hold_if = Pipe_Hold;
          hold_id = Pipe_Clear;
        end
      end
      FLUSH: begin
        hold_id = Pipe_Clear;
        // A new jump restarts the flush window; interrupts wait for IDLE
        if (bus.jump_req_i) begin
          jflag   = 1'b1;
          jaddr   = bus.jump_addr_i;
          hold_if = Pipe_Clear;
          cnt_d   = 3'(FLUSH_CYCLES);
        end else if (cnt_q <= 3'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - 3'd1;
        end
      end
      MDU_WAIT: begin
        hold_pc = Pipe_Hold;
        hold_if = Pipe_Hold;
        hold_id = Pipe_Hold;
        if (bus.mdu_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are combinational, so reset must mask input-driven events too
  assign bus.hold_pc_o   = rst_i ? Pipe_Flow : hold_pc;
  assign bus.hold_if_o   = rst_i ? Pipe_Flow : hold_if;
  assign bus.hold_id_o   = rst_i ? Pipe_Flow : hold_id;
  assign bus.jump_flag_o = rst_i ? 1'b0 : jflag;
  assign bus.jump_addr_o = rst_i ? '0 : jaddr;
  assign bus.int_ack_o   = rst_i ? 1'b0 : ack;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hold_pc == Pipe_Hold && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (jflag && flush_cnt_q != 32'hFFFF_FFFF)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with FLUSH_CYCLES=2; checks outputs 2 time units after each rising edge.
module tb_pipe_ctrl;
  import tinyriscv_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_asrt = 0;
  int   n_fail = 0;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [5:0] ALL_FLOW = {Pipe_Flow,  Pipe_Flow,  Pipe_Flow};
  localparam logic [5:0] REDIR    = {Pipe_Flow,  Pipe_Clear, Pipe_Clear};
  localparam logic [5:0] FLSH     = {Pipe_Flow,  Pipe_Flow,  Pipe_Clear};
  localparam logic [5:0] ALL_HOLD = {Pipe_Hold,  Pipe_Hold,  Pipe_Hold};
  localparam logic [5:0] LDUSE    = {Pipe_Hold,  Pipe_Hold,  Pipe_Clear};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // holds, jump flag, jump address, int ack in one go
  task automatic chk_out(input string tag, input logic [5:0] h, input logic jf,
                         input logic [31:0] ja, input logic ak);
    chk({tag, ".hold"}, 32'({bus.hold_pc_o, bus.hold_if_o, bus.hold_id_o}), 32'(h));
    chk({tag, ".jflag"}, 32'(bus.jump_flag_o), 32'(jf));
    chk({tag, ".jaddr"}, bus.jump_addr_o, ja);
    chk({tag, ".ack"}, 32'(bus.int_ack_o), 32'(ak));
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_in();
    bus.jump_req_i  = 0; bus.jump_addr_i = '0;
    bus.int_req_i   = 0; bus.int_addr_i  = '0;
    bus.ex_load_i   = 0; bus.ex_rd_i     = '0;
    bus.id_rs1_re_i = 0; bus.id_rs1_i    = '0;
    bus.id_rs2_re_i = 0; bus.id_rs2_i    = '0;
    bus.mdu_start_i = 0; bus.mdu_done_i  = 0;
  endtask

  initial begin
    clr_in();
    // reset: outputs flow even with a jump request present
    #2;
    chk_out("rst_idle", ALL_FLOW, 0, 0, 0);
    bus.jump_req_i = 1; bus.jump_addr_i = 32'h55;
    settle();
    chk_out("rst_mask", ALL_FLOW, 0, 0, 0);
    clr_in();
    tick();
    rst_i = 0;
    settle();
    chk_out("post_rst", ALL_FLOW, 0, 0, 0);

    // jump with FLUSH_CYCLES=2
    tick();
    bus.jump_req_i = 1; bus.jump_addr_i = 32'h100;
    settle();
    chk_out("jmp_N", REDIR, 1, 32'h100, 0);
    tick(); clr_in(); settle();
    chk_out("jmp_N1", FLSH, 0, 0, 0);
    tick(); settle();
    chk_out("jmp_N2", FLSH, 0, 0, 0);
    tick(); settle();
    chk_out("jmp_N3", ALL_FLOW, 0, 0, 0);

    // load-use on rs2, then x0 destination, then disabled rs1 read
    bus.ex_load_i = 1; bus.ex_rd_i = 5; bus.id_rs2_re_i = 1; bus.id_rs2_i = 5;
    settle();
    chk_out("lu_rs2", LDUSE, 0, 0, 0);
    tick(); settle();
    chk_out("lu_once", LDUSE, 0, 0, 0);
    bus.ex_rd_i = 0; bus.id_rs2_i = 0;
    settle();
    chk_out("lu_x0", ALL_FLOW, 0, 0, 0);
    bus.ex_rd_i = 7; bus.id_rs2_re_i = 0; bus.id_rs1_i = 7; bus.id_rs1_re_i = 0;
    settle();
    chk_out("lu_nore", ALL_FLOW, 0, 0, 0);
    bus.id_rs1_re_i = 1;
    settle();
    chk_out("lu_rs1", LDUSE, 0, 0, 0);
    // mdu start outranks load-use
    bus.mdu_start_i = 1; bus.mdu_done_i = 1;
    settle();
    chk_out("mdu_1cyc", ALL_HOLD, 0, 0, 0);
    tick(); clr_in(); settle();
    chk_out("mdu_1cyc_end", ALL_FLOW, 0, 0, 0);

    // mdu with done four cycles later; jump mid-wait ignored
    bus.mdu_start_i = 1;
    settle();
    chk_out("mdu_N", ALL_HOLD, 0, 0, 0);
    tick(); bus.mdu_start_i = 0; bus.jump_req_i = 1; bus.jump_addr_i = 32'h200; settle();
    chk_out("mdu_N1_jmp", ALL_HOLD, 0, 0, 0);
    tick(); bus.jump_req_i = 0; bus.int_req_i = 1; bus.int_addr_i = 32'h44; settle();
    chk_out("mdu_N2_int", ALL_HOLD, 0, 0, 0);
    tick(); bus.int_req_i = 0; settle();
    chk_out("mdu_N3", ALL_HOLD, 0, 0, 0);
    tick(); bus.mdu_done_i = 1; settle();
    chk_out("mdu_N4", ALL_HOLD, 0, 0, 0);
    tick(); clr_in(); settle();
    chk_out("mdu_N5", ALL_FLOW, 0, 0, 0);

    // jump beats interrupt; interrupt taken once back in IDLE
    bus.jump_req_i = 1; bus.jump_addr_i = 32'h300;
    bus.int_req_i  = 1; bus.int_addr_i  = 32'h80;
    settle();
    chk_out("ji_N", REDIR, 1, 32'h300, 0);
    tick(); bus.jump_req_i = 0; settle();
    chk_out("ji_fl1", FLSH, 0, 0, 0);
    tick(); settle();
    chk_out("ji_fl2", FLSH, 0, 0, 0);
    tick(); settle();
    chk_out("int_take", REDIR, 1, 32'h80, 1);
    tick(); bus.int_req_i = 0; settle();
    chk_out("int_fl1", FLSH, 0, 0, 0);
    // jump inside FLUSH restarts the window
    bus.jump_req_i = 1; bus.jump_addr_i = 32'h400;
    settle();
    chk_out("fl_rejmp", REDIR, 1, 32'h400, 0);
    tick(); bus.jump_req_i = 0; settle();
    chk_out("rejmp_fl1", FLSH, 0, 0, 0);
    tick(); settle();
    chk_out("rejmp_fl2", FLSH, 0, 0, 0);
    tick(); settle();
    chk_out("rejmp_end", ALL_FLOW, 0, 0, 0);

    // reset asserted during MDU_WAIT
    bus.mdu_start_i = 1;
    tick(); bus.mdu_start_i = 0; settle();
    chk_out("rst_mdu_wait", ALL_HOLD, 0, 0, 0);
    rst_i = 1;
    settle();
    chk_out("rst_mdu_async", ALL_FLOW, 0, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
    chk("rst_stall_cnt", bus.stall_cnt_o, 32'd0);
    chk("rst_flush_cnt", bus.flush_cnt_o, 32'd0);
`endif
    tick(); rst_i = 0; settle();
    chk_out("rst_mdu_idle", ALL_FLOW, 0, 0, 0);
    tick(); settle();
    chk_out("rst_mdu_idle2", ALL_FLOW, 0, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
    chk("idle_stall_cnt", bus.stall_cnt_o, 32'd0);
    chk("idle_flush_cnt", bus.flush_cnt_o, 32'd0);
    bus.jump_req_i = 1; bus.jump_addr_i = 32'h10;
    tick(); clr_in(); settle();
    chk("flush_cnt_one", bus.flush_cnt_o, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, range 0..7: extra Pipe_Clear cycles on hold_id_o after a redirect.
REQ-002 The design SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk_i  in  1  clock, rising edge.
REQ-004 rst_i  in  1  async active-high reset.
REQ-005 jump_req_i  in  1  EX-stage branch/jump taken.
REQ-006 jump_addr_i  in  InstAddrBus  jump target.
REQ-007 int_req_i  in  1  interrupt redirect request, level.
REQ-008 int_addr_i  in  InstAddrBus  interrupt vector.
REQ-009 ex_load_i  in  1  instruction in EX is a load.
REQ-010 ex_rd_i  in  RegAddrBus  load destination register.
REQ-011 id_rs1_re_i  in  1  ID reads rs1.
REQ-012 id_rs1_i  in  RegAddrBus  ID rs1 address.
REQ-013 id_rs2_re_i  in  1  ID reads rs2.
REQ-014 id_rs2_i  in  RegAddrBus  ID rs2 address.
REQ-015 mdu_start_i  in  1  multi-cycle mul/div issued in EX.
REQ-016 mdu_done_i  in  1  mul/div result valid, one-cycle pulse.
REQ-017 hold_pc_o  out  Hold_Flag_Bus  PC register control.
REQ-018 hold_if_o  out  Hold_Flag_Bus  IF/ID register control.
REQ-019 hold_id_o  out  Hold_Flag_Bus  ID/EX register control.
REQ-020 jump_flag_o  out  1  PC load strobe.
REQ-021 jump_addr_o  out  InstAddrBus  PC load value.
REQ-022 int_ack_o  out  1  interrupt accepted, one-cycle pulse.
REQ-023 stall_cnt_o, flush_cnt_o  out  32 each  perf counters, present only with PIPE_CTRL_PERF_EN.

Function
REQ-024 States SHALL be IDLE, FLUSH, MDU_WAIT; all outputs combinational from state and current inputs.
REQ-025 Priority in IDLE, highest first: jump_req_i, int_req_i, mdu_start_i, load-use.
REQ-026 Redirect in IDLE (jump or int), cycle N: jump_flag_o=1, jump_addr_o=selected target, hold_if_o=hold_id_o=Pipe_Clear, hold_pc_o=Pipe_Flow; int_ack_o=1 only if int_req_i won.
REQ-027 FLUSH_CYCLES=0: stay IDLE after redirect; else go to FLUSH, load counter=FLUSH_CYCLES, emit hold_id_o=Pipe_Clear per FLUSH cycle (others Pipe_Flow), return to IDLE when counter reaches 1.
REQ-028 In FLUSH, jump_req_i SHALL restart redirect and reload counter; int_req_i SHALL wait until IDLE.
REQ-029 mdu_start_i in IDLE: hold_pc_o=hold_if_o=hold_id_o=Pipe_Hold from cycle N until mdu_done_i cycle inclusive; mdu_done_i in the start cycle means single-cycle hold; otherwise go to MDU_WAIT.
REQ-030 In MDU_WAIT, jump_req_i and int_req_i are ignored; mdu_done_i returns to IDLE next edge.
REQ-031 Load-use = ex_load_i & ex_rd_i!=0 & ((id_rs1_re_i & id_rs1_i==ex_rd_i) | (id_rs2_re_i & id_rs2_i==ex_rd_i)); response: hold_pc_o=hold_if_o=Pipe_Hold, hold_id_o=Pipe_Clear, exactly one cycle.
REQ-032 With no event: all hold outputs Pipe_Flow, jump_flag_o=0, jump_addr_o=0.

Reset
REQ-033 rst_i asserted at any time, including mid-FLUSH or mid-MDU_WAIT: state=IDLE, flush counter=0, perf counters=0 immediately.
REQ-034 During reset: hold outputs Pipe_Flow, jump_flag_o=0, jump_addr_o=0, int_ack_o=0.

Configuration
REQ-035 Macro PIPE_CTRL_PERF_EN defined: stall_cnt_o counts cycles with hold_pc_o=Pipe_Hold; flush_cnt_o counts cycles with jump_flag_o=1; both saturate at 32'hFFFF_FFFF.
REQ-036 Macro undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-037 Pipe_Flow, Pipe_Hold, Pipe_Clear, Hold_Flag_Bus and the state enum SHALL live in tinyriscv_pkg.
REQ-038 Sub-module hazard_detect SHALL hold the REQ-031 load-use compare; FSM and counters stay in pipe_ctrl.

Verification
REQ-039 jump_req_i=1, jump_addr_i=32'h100, FLUSH_CYCLES=2 -> cycle N jump_flag_o=1, addr 32'h100, IF/ID Clear; N+1, N+2 hold_id_o=Clear; N+3 all Flow.
REQ-040 ex_load_i=1, ex_rd_i=5, id_rs2_re_i=1, id_rs2_i=5 -> one cycle PC/IF Hold, ID Clear; ex_rd_i=0 -> no stall.
REQ-041 mdu_start_i, mdu_done_i 4 cycles later -> 5 cycles all Hold, then Flow; jump_req_i pulsed mid-wait ignored.
REQ-042 jump_req_i and int_req_i same cycle -> jump target used, int_ack_o=0; int accepted once IDLE with int_ack_o pulse.
REQ-043 rst_i asserted in MDU_WAIT -> next cycle all Flow, state IDLE; with PIPE_CTRL_PERF_EN counters read 0.
